// File: rtl/vgac_pipe.sv
`default_nettype none
// =====================================================================
// vgac_pipe : VGA timing, pixel-RAM addressing and aligned RGB/sync output
// Rev 1.0   : initial release
// =====================================================================
module vgac_pipe #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 4,
  parameter int RD_LAT   = 0,
  parameter int ROW_W    = 9,
  parameter int COL_W    = 10
) (
  input  logic              vga_clk,
  input  logic              clrn,
  input  logic [3*CW-1:0]   d_in,
  input  logic              swap_req,
  output logic [ROW_W-1:0]  row_addr,
  output logic [COL_W-1:0]  col_addr,
  output logic              rdn,
  output logic              buf_sel,
  output logic [CW-1:0]     r,
  output logic [CW-1:0]     g,
  output logic [CW-1:0]     b,
  output logic              hs,
  output logic              vs,
  output logic              de,
  output logic              vblank,
  output logic              line_start,
  output logic              frame_start,
  output logic              swap_ack
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_E  = HW'(H_SYNC);
  localparam logic [HW-1:0] H_ACT_BEG = HW'(H_SYNC + H_BP);
  localparam logic [HW-1:0] H_ACT_END = HW'(H_SYNC + H_BP + H_ACTIVE);

  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_E  = VW'(V_SYNC);
  localparam logic [VW-1:0] V_ACT_BEG = VW'(V_SYNC + V_BP);
  localparam logic [VW-1:0] V_ACT_END = VW'(V_SYNC + V_BP + V_ACTIVE);

  localparam logic [COL_W-1:0] COL_OFS = COL_W'(H_SYNC + H_BP);
  localparam logic [ROW_W-1:0] ROW_OFS = ROW_W'(V_SYNC + V_BP);

  logic [HW-1:0] h;
  logic [VW-1:0] v;

  logic h_last, frame_wrap;
  logic hsync_now, vsync_now;
  logic act_h, act_v, act_now;
  logic [COL_W-1:0] col_next;
  logic [ROW_W-1:0] row_next;

  assign h_last     = (h == H_LAST);
  assign frame_wrap = h_last && (v == V_LAST);

  assign hsync_now = (h < H_SYNC_E);
  assign vsync_now = (v < V_SYNC_E);
  assign act_h     = (h >= H_ACT_BEG) && (h < H_ACT_END);
  assign act_v     = (v >= V_ACT_BEG) && (v < V_ACT_END);
  assign act_now   = act_h && act_v;

  // Subtract in the address width so truncation falls out of the arithmetic.
  assign col_next = COL_W'(h) - COL_OFS;
  assign row_next = ROW_W'(v) - ROW_OFS;

  // ------------------------------------------------------------------
  // Raster counters
  // ------------------------------------------------------------------
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      h <= '0;
      v <= '0;
    end else if (h_last) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  // ------------------------------------------------------------------
  // Stage 1: RAM address / read strobe and event pulses
  // ------------------------------------------------------------------
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      rdn         <= 1'b1;
      col_addr    <= '0;
      row_addr    <= '0;
      vblank      <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      rdn         <= ~act_now;
      col_addr    <= act_now ? col_next : '0;
      row_addr    <= act_now ? row_next : '0;
      vblank      <= ~act_v;
      line_start  <= (h == '0);
      frame_start <= (h == '0) && (v == '0);
    end
  end

  // ------------------------------------------------------------------
  // Timing delay line {hsync, vsync, act}; entry 0 lines up with the
  // address stage, entry RD_LAT with the cycle d_in is valid.
  // ------------------------------------------------------------------
  logic [2:0] dly [0:RD_LAT];
  logic [2:0] tap;

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i <= RD_LAT; i++) dly[i] <= 3'b000;
    end else begin
      dly[0] <= {hsync_now, vsync_now, act_now};
      for (int i = 1; i <= RD_LAT; i++) dly[i] <= dly[i-1];
    end
  end

  assign tap = dly[RD_LAT];

  // ------------------------------------------------------------------
  // Output stage
  // ------------------------------------------------------------------
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      r  <= '0;
      g  <= '0;
      b  <= '0;
      de <= 1'b0;
      hs <= ~HS_POL;
      vs <= ~VS_POL;
    end else begin
      r  <= tap[0] ? d_in[CW-1:0]      : '0;
      g  <= tap[0] ? d_in[2*CW-1:CW]   : '0;
      b  <= tap[0] ? d_in[3*CW-1:2*CW] : '0;
      de <= tap[0];
      hs <= tap[2] ? HS_POL : ~HS_POL;
      vs <= tap[1] ? VS_POL : ~VS_POL;
    end
  end

  // ------------------------------------------------------------------
  // Double-buffer swap: requests latch into pend and are served at the
  // frame wrap; a request in the wrap cycle itself is served directly.
  // ------------------------------------------------------------------
  logic pend;

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      pend     <= 1'b0;
      buf_sel  <= 1'b0;
      swap_ack <= 1'b0;
    end else if (frame_wrap && (pend || swap_req)) begin
      pend     <= 1'b0;
      buf_sel  <= ~buf_sel;
      swap_ack <= 1'b1;
    end else begin
      pend     <= pend | swap_req;
      swap_ack <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vgac_pipe.sv
`default_nettype none
// =====================================================================
// tb_vgac_pipe : directed self-checking bench for vgac_pipe
// Rev 1.0   : initial release
// =====================================================================
module tb_vgac_pipe;

  logic vga_clk = 1'b0;
  logic clrn    = 1'b0;
  always #5 vga_clk = ~vga_clk;

  int checks   = 0;
  int failures = 0;
  int k        = 0;
  int hs0_low  = 0;
  int vs0_low  = 0;
  int hs2_high = 0;
  int de0_cnt  = 0;
  int de1_cnt  = 0;

  // u0: default timing, RD_LAT=0
  logic [11:0] d_in0 = 12'hABC;
  logic        req0  = 1'b0;
  logic [8:0]  row0;
  logic [9:0]  col0;
  logic        rdn0, bsel0, hs0, vs0, de0, vbl0, ls0, fs0, ack0;
  logic [3:0]  r0, g0, b0;

  vgac_pipe u0 (
    .vga_clk(vga_clk), .clrn(clrn), .d_in(d_in0), .swap_req(req0),
    .row_addr(row0), .col_addr(col0), .rdn(rdn0), .buf_sel(bsel0),
    .r(r0), .g(g0), .b(b0), .hs(hs0), .vs(vs0), .de(de0), .vblank(vbl0),
    .line_start(ls0), .frame_start(fs0), .swap_ack(ack0)
  );

  // u1: tiny raster (15 x 8 = 120 cycles/frame), RD_LAT=3
  logic [11:0] d_in1;
  logic        req1 = 1'b0;
  logic [8:0]  row1;
  logic [9:0]  col1;
  logic        rdn1, bsel1, hs1, vs1, de1, vbl1, ls1, fs1, ack1;
  logic [3:0]  r1, g1, b1;

  vgac_pipe #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .RD_LAT(3)
  ) u1 (
    .vga_clk(vga_clk), .clrn(clrn), .d_in(d_in1), .swap_req(req1),
    .row_addr(row1), .col_addr(col1), .rdn(rdn1), .buf_sel(bsel1),
    .r(r1), .g(g1), .b(b1), .hs(hs1), .vs(vs1), .de(de1), .vblank(vbl1),
    .line_start(ls1), .frame_start(fs1), .swap_ack(ack1)
  );

  // 3-cycle RAM model for u1: pixel = {b=row, g=col, r=5}
  logic [11:0] ram_q [0:2];
  always @(posedge vga_clk) begin
    ram_q[0] <= rdn1 ? 12'h000 : {row1[3:0], col1[3:0], 4'h5};
    ram_q[1] <= ram_q[0];
    ram_q[2] <= ram_q[1];
  end
  assign d_in1 = ram_q[2];

  // u2: positive syncs, 800-wide line, short frame
  logic [11:0] d_in2 = 12'h123;
  logic        req2  = 1'b0;
  logic [8:0]  row2;
  logic [9:0]  col2;
  logic        rdn2, bsel2, hs2, vs2, de2, vbl2, ls2, fs2, ack2;
  logic [3:0]  r2, g2, b2;

  vgac_pipe #(
    .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) u2 (
    .vga_clk(vga_clk), .clrn(clrn), .d_in(d_in2), .swap_req(req2),
    .row_addr(row2), .col_addr(col2), .rdn(rdn2), .buf_sel(bsel2),
    .r(r2), .g(g2), .b(b2), .hs(hs2), .vs(vs2), .de(de2), .vblank(vbl2),
    .line_start(ls2), .frame_start(fs2), .swap_ack(ack2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic acc();
    if (hs0 == 1'b0) hs0_low++;
    if (vs0 == 1'b0) vs0_low++;
    if (hs2 == 1'b1) hs2_high++;
    if (de0 == 1'b1) de0_cnt++;
    if (de1 == 1'b1) de1_cnt++;
  endtask

  // k = cycles since reset release; counter state at cycle k is (k mod H_TOTAL, ...)
  task automatic step();
    @(posedge vga_clk);
    #1;
    k++;
    acc();
  endtask

  task automatic goto(input int t);
    while (k < t) step();
  endtask

  initial begin
    repeat (10) @(posedge vga_clk);
    #1;
    chk("rst_row0", row0, 0);    chk("rst_col0", col0, 0);
    chk("rst_rdn0", rdn0, 1);    chk("rst_bsel0", bsel0, 0);
    chk("rst_r0", r0, 0);        chk("rst_g0", g0, 0);       chk("rst_b0", b0, 0);
    chk("rst_hs0", hs0, 1);      chk("rst_vs0", vs0, 1);     chk("rst_de0", de0, 0);
    chk("rst_vbl0", vbl0, 1);    chk("rst_ls0", ls0, 0);     chk("rst_fs0", fs0, 0);
    chk("rst_ack0", ack0, 0);
    chk("rst_hs1", hs1, 1);      chk("rst_hs2", hs2, 0);     chk("rst_vs2", vs2, 0);

    clrn = 1'b1;
    acc();

    goto(1);  chk("ls0_first", ls0, 1); chk("fs0_first", fs0, 1); chk("fs1_first", fs1, 1);
              chk("hs2_k1", hs2, 0);
    goto(2);  chk("ls0_k2", ls0, 0);    chk("fs0_k2", fs0, 0);     chk("hs0_fall", hs0, 0);
              chk("hs2_rise", hs2, 1);
    goto(4);  chk("hs1_k4", hs1, 1);
    goto(5);  chk("hs1_fall", hs1, 0);
    goto(7);  chk("hs1_k7", hs1, 0);
    goto(8);  chk("hs1_rise", hs1, 1);
    goto(19); chk("hs1_k19", hs1, 1);
    goto(20); chk("hs1_fall2", hs1, 0);
    goto(45); chk("vbl1_k45", vbl1, 1);
    goto(46); chk("vbl1_k46", vbl1, 0);
    goto(50); chk("rdn1_k50", rdn1, 1);
    goto(51); chk("rdn1_k51", rdn1, 0); chk("col1_k51", col1, 0); chk("row1_k51", row1, 0);
    goto(54); chk("de1_k54", de1, 0);
    goto(55); chk("de1_rise", de1, 1);  chk("r1_k55", r1, 5); chk("g1_k55", g1, 0); chk("b1_k55", b1, 0);
    goto(58); chk("col1_k58", col1, 7);
    goto(59); chk("rdn1_k59", rdn1, 1); chk("col1_k59", col1, 0);
    goto(62); chk("de1_k62", de1, 1);   chk("g1_k62", g1, 7);
    goto(63); chk("de1_k63", de1, 0);   chk("g1_k63", g1, 0);
    goto(70); chk("de1_k70", de1, 1);   chk("g1_k70", g1, 0); chk("b1_k70", b1, 1);
    goto(97); chk("hs0_k97", hs0, 0);
    goto(98); chk("hs0_k98", hs0, 1);
    goto(119); chk("de1_frame_cnt", de1_cnt, 32); chk("bsel1_k119", bsel1, 0);
    goto(120); chk("ack1_k120", ack1, 0);
    goto(129); chk("hs2_k129", hs2, 1);
    goto(130); chk("hs2_k130", hs2, 0);

    // swap: mid-frame pulse
    req1 = 1'b1; step(); req1 = 1'b0;
    goto(239); chk("sw1_bsel_pre", bsel1, 0); chk("sw1_ack_pre", ack1, 0);
    goto(240); chk("sw1_bsel", bsel1, 1);     chk("sw1_ack", ack1, 1);
    goto(241); chk("sw1_ack_end", ack1, 0);   chk("sw1_bsel_hold", bsel1, 1);

    // swap: pulse on the wrap cycle itself
    goto(359); req1 = 1'b1; step(); req1 = 1'b0;
    chk("sw2_bsel", bsel1, 0); chk("sw2_ack", ack1, 1);
    goto(480); chk("sw2_nopend_bsel", bsel1, 0); chk("sw2_nopend_ack", ack1, 0);

    // swap: three pulses merge
    goto(490); req1 = 1'b1; step(); req1 = 1'b0;
    goto(500); req1 = 1'b1; step(); req1 = 1'b0;
    goto(510); req1 = 1'b1; step(); req1 = 1'b0;
    goto(600); chk("sw3_bsel", bsel1, 1); chk("sw3_ack", ack1, 1);
    goto(601); chk("sw3_ack_end", ack1, 0);
    goto(720); chk("sw3_once_bsel", bsel1, 1); chk("sw3_once_ack", ack1, 0);

    // swap: held request toggles once per frame
    goto(725); req1 = 1'b1;
    goto(799); chk("hs0_low_line", hs0_low, 96);
    goto(801); chk("hs0_k801", hs0, 1);
    goto(802); chk("hs0_period", hs0, 0);
    goto(840); chk("sw4_bsel_a", bsel1, 0); chk("sw4_ack_a", ack1, 1);
    goto(841); chk("sw4_ack_a_end", ack1, 0);
    goto(960); req1 = 1'b0;
    chk("sw4_bsel_b", bsel1, 1); chk("sw4_ack_b", ack1, 1);
    goto(1055); chk("hs2_high_cnt", hs2_high, 128);
    goto(1057); chk("hs2_k1057", hs2, 0);
    goto(1058); chk("hs2_period", hs2, 1);
    goto(1080); chk("sw4_end_bsel", bsel1, 1); chk("sw4_end_ack", ack1, 0);
    goto(1599); chk("hs0_low_2lines", hs0_low, 192);
    goto(1601); chk("vs0_k1601", vs0, 0);
    goto(1602); chk("vs0_k1602", vs0, 1);
    goto(2000); chk("vs0_low_cnt", vs0_low, 1600);

    // u2 column sweep on the first active line
    goto(2328); chk("rdn2_pre", rdn2, 1);
    for (int j = 0; j < 800; j++) begin
      step();
      chk("col2_sweep", col2, j);
    end
    chk("row2_sweep", row2, 0);
    step(); chk("rdn2_post", rdn2, 1); chk("col2_post", col2, 0);

    // u0 first active pixel
    goto(28145); chk("de0_pre", de0, 0); chk("r0_pre", r0, 0);
    goto(28146); chk("de0_rise", de0, 1);
                 chk("r0_px", r0, 4'hC); chk("g0_px", g0, 4'hB); chk("b0_px", b0, 4'hA);
    goto(28785); chk("de0_last", de0, 1);
    goto(28786); chk("de0_fall", de0, 0); chk("de0_line_cnt", de0_cnt, 640);

    // asynchronous reset in the middle of an active line of u1
    goto(28867); chk("hs0_pre_rst", hs0, 0); chk("rdn1_pre_rst", rdn1, 0);
    clrn = 1'b0;
    #1;
    chk("arst_hs0", hs0, 1);   chk("arst_rdn1", rdn1, 1); chk("arst_col1", col1, 0);
    chk("arst_row1", row1, 0); chk("arst_vbl1", vbl1, 1); chk("arst_de1", de1, 0);
    chk("arst_hs2", hs2, 0);
    repeat (5) @(posedge vga_clk);
    #1;
    chk("rst_hold_fs0", fs0, 0); chk("rst_hold_ls0", ls0, 0);
    clrn = 1'b1;
    k = 0;
    step(); chk("rel_fs0", fs0, 1); chk("rel_ls0", ls0, 1); chk("rel_fs1", fs1, 1);
    step(); chk("rel_fs0_end", fs0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vgac_pipe.md
# vgac_pipe

Parametrised VGA display controller for the 25 MHz pixel domain. It generates programmable sync timing and pixel-RAM read addresses, and drives RGB with a configurable RAM read latency, keeping hs/vs/de aligned with the pixel data. It sits between the frame-buffer RAM and the VGA connector. It adds a double-buffer select with a vblank-synchronised swap handshake, plus line and frame event pulses for the game logic.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch / sync / back porch (lines)
- HS_POL / VS_POL, 0 / 0, active level of hs / vs during the sync pulse
- CW, 4, bits per colour channel
- RD_LAT, 0, pixel-RAM read latency in cycles (0..4; 0 = combinational RAM)
- ROW_W / COL_W, 9 / 10, address widths
- vga_clk  in  1  pixel clock
- clrn  in  1  reset, asynchronous, active-low
- d_in  in  3*CW  pixel {b,g,r}; r = d_in[CW-1:0]
- swap_req  in  1  request to swap display buffer (pulse or level)
- row_addr  out  ROW_W  pixel-RAM row
- col_addr  out  COL_W  pixel-RAM column
- rdn  out  1  pixel-RAM read, active-low
- buf_sel  out  1  frame buffer currently displayed
- r, g, b  out  CW each  colour outputs
- hs, vs  out  1  syncs, aligned with r/g/b
- de  out  1  display enable, aligned with r/g/b
- vblank  out  1  high outside active lines
- line_start, frame_start  out  1  one-cycle event pulses
- swap_ack  out  1  one-cycle pulse when buf_sel toggles

## Operation
- H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP (800). V_TOTAL is defined the same way (525).
- Horizontal counter h:
  - counts 0..H_TOTAL-1, then wraps to 0.
- Vertical counter v:
  - advances only when h = H_TOTAL-1;
  - counts 0..V_TOTAL-1, then wraps to 0.
- Both counters reset asynchronously.
- Line order is sync, back porch, active, front porch:
  - hsync region: h < H_SYNC;
  - active columns: H_SYNC+H_BP ≤ h < H_SYNC+H_BP+H_ACTIVE (144..783).
  - Vertical is the same: vsync lines v < V_SYNC; active lines 35..514.
- act = active column AND active line.
- Stage 1 (registered from counters):
  - rdn = ~act;
  - col_addr = h-(H_SYNC+H_BP) and row_addr = v-(V_SYNC+V_BP), truncated to width; both forced to 0 when act=0;
  - vblank = line not active;
  - line_start = (h = 0); frame_start = (h = 0 and v = 0).
- Delay line: hs_raw, vs_raw and act are delayed RD_LAT+1 further cycles, so they leave with r/g/b.
- Output stage:
  - r/g/b = d_in channels when the delayed act is 1, else 0;
  - de = delayed act;
  - hs = HS_POL when delayed hsync, else ~HS_POL; vs likewise.
- Swap handshake:
  - swap_req high in any cycle sets pend.
  - At the frame wrap cycle (h = H_TOTAL-1, v = V_TOTAL-1), if pend or swap_req: buf_sel toggles, swap_ack pulses high one cycle, pend clears.
  - A swap_req coinciding with the wrap is served in that same wrap and does not leave pend set.
  - Multiple requests within one frame merge into a single swap.
  - swap_req held high toggles buf_sel once per frame.

## Timing
- Reset values:
  - h, v, pend, buf_sel, swap_ack, line_start, frame_start, de, r, g, b = 0;
  - row_addr = col_addr = 0; rdn = 1; vblank = 1;
  - hs = ~HS_POL, vs = ~VS_POL;
  - all delay-line stages reset inactive.
- Address latency: addresses and rdn are valid one cycle after the counter state they decode.
- Data latency: d_in is sampled RD_LAT cycles after its address is presented.
- End to end: r/g/b/de/hs/vs appear RD_LAT+2 cycles after the counter state, all mutually aligned.
- Reset mid-frame restarts at h = v = 0 on the first clock after clrn deasserts. No partial pulses are emitted during reset.
- line_start and frame_start are exactly one cycle wide. frame_start coincides with a line_start.

## Test plan
- Reset with default parameters, hold clrn low for 10 cycles:
  - -> all outputs at their reset values;
  - -> after release, hs period is 800 cycles, low for 96;
  - -> vs period is 420000 cycles, low for 1600.
- RD_LAT=0, d_in = 12'hABC:
  - -> first de=1 two cycles after (h=144, v=35), with r=C, g=B, b=A;
  - -> de stays high for exactly 640 cycles per line and 480 lines per frame.
- RD_LAT=3:
  - -> col_addr=0, row_addr=0 with rdn=0 one cycle after (h=144, v=35);
  - -> de rises 5 cycles after that counter state;
  - -> the hs falling edge lies exactly 5 cycles after h=0.
- Swap handshake:
  - pulse swap_req mid-frame -> buf_sel toggles and swap_ack=1 on the wrap cycle only;
  - pulse again on the wrap cycle itself -> single toggle, pend=0;
  - 3 pulses in one frame -> one toggle.
- HS_POL=1, VS_POL=1, H_ACTIVE=800, H_FP=40, H_SYNC=128, H_BP=88:
  - -> hs period is 1056 with a 128-cycle high pulse;
  - -> col_addr sweeps 0..799.
- Assert clrn low at (h=400, v=200):
  - -> outputs return to reset values immediately;
  - -> after release, frame_start pulses on the first cycle.
